sd_request_arbiter: RTL

//  Shares one sd_card_controller between two requesters (0, 1), each issuing whole-sector READ/WRITE jobs.

---
 rtl/sd_request_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sd_request_arbiter.sv
// Round-robin arbiter that shares one SD card controller between two sector-job requesters.
// Launches the controller, routes byte strobes/data to the owner, checks byte count and watchdogs the job.
module sd_request_arbiter #(
  parameter int unsigned SECTOR_BYTES  = 512,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned XFER_TIMEOUT  = 2**20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_op,
  input  logic [25:0] req_addr0,
  input  logic [25:0] req_addr1,
  input  logic [7:0]  wr_byte0,
  input  logic [7:0]  wr_byte1,
  output logic [1:0]  gnt,
  output logic [1:0]  byte_strobe,
  output logic [7:0]  rd_byte,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        sd_op_code,
  output logic        sd_execute,
  output logic [25:0] sd_sector_address,
  output logic [7:0]  sd_outgoing_byte,
  input  logic [7:0]  sd_incoming_byte,
  input  logic        sd_finished_byte,
  input  logic        sd_finished_sector,
  input  logic        sd_busy
);

  localparam logic [9:0]  FULL_CNT  = 10'(SECTOR_BYTES);
  localparam logic [9:0]  OVER_CNT  = 10'(SECTOR_BYTES + 1);
  localparam logic [20:0] START_LIM = 21'(START_TIMEOUT - 1);
  localparam logic [20:0] XFER_LIM  = 21'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, XFER, RELEASE} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_d, strobe_d, done_d, err_d;
  logic        exec_d, op_d;
  logic [25:0] addr_d;
  logic [7:0]  rd_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d, byte_next;
  logic [20:0] tmo_q, tmo_d, tmo_next;
  logic        fb_q, fs_q;
  logic        fb_rise, fs_rise;
  logic        pick;
  logic [1:0]  owner_oh;

  assign fb_rise   = sd_finished_byte & ~fb_q;
  assign fs_rise   = sd_finished_sector & ~fs_q;
  // On a tie the requester not served last wins; otherwise the sole requester wins.
  assign pick      = (req == 2'b11) ? ~last_q : req[1];
  assign owner_oh  = owner_q ? 2'b10 : 2'b01;
  assign byte_next = (fb_rise && byte_cnt_q != '1) ? byte_cnt_q + 10'd1 : byte_cnt_q;
  assign tmo_next  = (tmo_q != '1) ? tmo_q + 21'd1 : tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      owner_q           <= 1'b0;
      last_q            <= 1'b1;
      gnt               <= '0;
      byte_strobe       <= '0;
      done              <= '0;
      err               <= '0;
      sd_execute        <= 1'b0;
      sd_op_code        <= 1'b0;
      sd_sector_address <= '0;
      rd_byte           <= '0;
      byte_cnt_q        <= '0;
      tmo_q             <= '0;
      fb_q              <= 1'b0;
      fs_q              <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      last_q            <= last_d;
      gnt               <= gnt_d;
      byte_strobe       <= strobe_d;
      done              <= done_d;
      err               <= err_d;
      sd_execute        <= exec_d;
      sd_op_code        <= op_d;
      sd_sector_address <= addr_d;
      rd_byte           <= rd_d;
      byte_cnt_q        <= byte_cnt_d;
      tmo_q             <= tmo_d;
      fb_q              <= sd_finished_byte;
      fs_q              <= sd_finished_sector;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt_d      = gnt;
    strobe_d   = '0;
    done_d     = '0;
    err_d      = '0;
    exec_d     = 1'b0;
    op_d       = sd_op_code;
    addr_d     = sd_sector_address;
    rd_d       = rd_byte;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;

    case (state_q)
      IDLE: begin
        if ((|req) && !sd_busy) begin
          owner_d = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          op_d    = req_op[pick];
          addr_d  = pick ? req_addr1 : req_addr0;
          state_d = LAUNCH;
        end
      end

      LAUNCH: begin
        exec_d     = 1'b1;
        byte_cnt_d = '0;
        tmo_d      = '0;
        state_d    = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        tmo_d = tmo_next;
        if (sd_busy) begin
          state_d = XFER;
        end else if (tmo_q >= START_LIM || tmo_q >= XFER_LIM) begin
          err_d   = owner_oh;
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = RELEASE;
        end
      end

      XFER: begin
        tmo_d      = tmo_next;
        byte_cnt_d = byte_next;
        if (fb_rise) begin
          strobe_d = owner_oh;
          rd_d     = sd_incoming_byte;
        end
        // byte_next already includes a byte edge coincident with the sector edge
        if (fs_rise) begin
          if (byte_next == FULL_CNT) done_d = owner_oh;
          else                       err_d  = owner_oh;
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = RELEASE;
        end else if (byte_next == OVER_CNT || tmo_q >= XFER_LIM) begin
          err_d   = owner_oh;
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (!sd_busy && !req[owner_q]) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sd_outgoing_byte = 8'hFF;
    if (gnt[1])      sd_outgoing_byte = wr_byte1;
    else if (gnt[0]) sd_outgoing_byte = wr_byte0;
  end

endmodule
